// File: rtl/neuron_argmax.sv
// Output-layer post-processing: ReLU-quantises each neuron sum into an activation
// stream and picks the winning class (running signed argmax) per sample.
module neuron_argmax #(
  parameter int DW          = 22,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4,
  parameter int SHIFT       = 6,
  parameter int AW          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DW-1:0]    din,
  input  logic                    din_valid,
  input  logic                    din_last,
  output logic [AW-1:0]           act_out,
  output logic                    act_valid,
  output logic [IDX_W-1:0]        act_idx,
  output logic [IDX_W-1:0]        class_idx,
  output logic signed [DW-1:0]    max_val,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Negative sums clip to zero; anything above the activation range saturates.
  function automatic logic [AW-1:0] relu_quant(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] sh;
    sh = x >>> SHIFT;
    if (x[DW-1]) begin
      relu_quant = '0;
    end else if (|sh[DW-1:AW]) begin
      relu_quant = '1;
    end else begin
      relu_quant = sh[AW-1:0];
    end
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic signed [DW-1:0]   run_max_q, run_max_d;
  logic [IDX_W-1:0]       best_idx_q, best_idx_d;
  logic [IDX_W-1:0]       class_idx_q, class_idx_d;
  logic signed [DW-1:0]   max_val_q, max_val_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [AW-1:0]          act_out_q, act_out_d;
  logic                   act_valid_q, act_valid_d;
  logic [IDX_W-1:0]       act_idx_q, act_idx_d;

  logic [IDX_W-1:0]       cur_idx_s;
  logic                   take_s;
  logic                   end_idx_s;
  logic signed [DW-1:0]   cand_max_s;
  logic [IDX_W-1:0]       cand_idx_s;

  // Candidate winner including the neuron on din; index 0 always starts a new max.
  always_comb begin
    cur_idx_s  = (state_q == SCAN) ? cnt_q : '0;
    take_s     = (state_q != SCAN) || (din > run_max_q);
    end_idx_s  = (cur_idx_s == LAST_IDX);
    cand_max_s = take_s ? din : run_max_q;
    cand_idx_s = take_s ? cur_idx_s : best_idx_q;
  end

  // Next-state, running max, result and activation computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    err_d       = err_q;
    done_d      = 1'b0;
    act_out_d   = act_out_q;
    act_valid_d = 1'b0;
    act_idx_d   = act_idx_q;

    if (din_valid) begin
      act_valid_d = 1'b1;
      act_out_d   = relu_quant(din);
      act_idx_d   = cur_idx_s;
      run_max_d   = cand_max_s;
      best_idx_d  = cand_idx_s;
      if (din_last || end_idx_s) begin
        // Framing is correct only when last and the final index coincide.
        state_d     = DONE;
        cnt_d       = '0;
        done_d      = 1'b1;
        class_idx_d = cand_idx_s;
        max_val_d   = cand_max_s;
        err_d       = din_last ^ end_idx_s;
      end else begin
        state_d = SCAN;
        cnt_d   = cur_idx_s + IDX_W'(1);
      end
    end else begin
      case (state_q)
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        SCAN:    state_d = SCAN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      act_out_q   <= '0;
      act_valid_q <= 1'b0;
      act_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      err_q       <= err_d;
      done_q      <= done_d;
      act_out_q   <= act_out_d;
      act_valid_q <= act_valid_d;
      act_idx_q   <= act_idx_d;
    end
  end

  assign act_out   = act_out_q;
  assign act_valid = act_valid_q;
  assign act_idx   = act_idx_q;
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/neuron_argmax.md
# neuron_argmax

Output-layer post-processing stage that sits directly downstream of `acc`. It consumes the signed 22-bit neuron sums that `acc` emits, one neuron per accepted word. For each neuron it produces a ReLU-quantized 8-bit activation stream for a following layer. It also tracks the running maximum over one sample's neurons and reports the winning class index (predicted digit) with a one-cycle `done` pulse.

## Interface
- `DW`, 22, width of the signed neuron sum from `acc`
- `NUM_CLASSES`, 10, neurons per sample
- `IDX_W`, 4, index width, must satisfy 2^IDX_W >= NUM_CLASSES
- `SHIFT`, 6, right shift applied before activation saturation
- `AW`, 8, activation output width (unsigned)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `din`  in  DW  signed neuron sum (two's complement)
- `din_valid`  in  1  `din` is accepted on this edge
- `din_last`  in  1  qualifies `din_valid`: this neuron is the last of the sample
- `act_out`  out  AW  quantized activation
- `act_valid`  out  1  `act_out` / `act_idx` valid this cycle
- `act_idx`  out  IDX_W  neuron index of `act_out`
- `class_idx`  out  IDX_W  winning neuron index of the last completed sample
- `max_val`  out  DW  signed sum of the winner
- `done`  out  1  one-cycle pulse: `class_idx` / `max_val` / `err` updated
- `err`  out  1  sample framing error, valid with `done`, held until next `done`

## Operation
- FSM states are IDLE, SCAN and DONE. Reset enters IDLE.
- IDLE: on `din_valid`, load the neuron as the running max with `best_idx = 0` and set `cnt = 1`. If `din_last` is also high, go to DONE; otherwise go to SCAN.
- SCAN: on `din_valid`, compare `din` (signed) with the running max.
  - Replace the max only if `din > max`, strictly, so ties keep the lower index.
  - Increment `cnt`.
- SCAN to DONE transition happens in either of two cases:
  - `din_last` is accepted.
  - The neuron at index NUM_CLASSES-1 is accepted, whether or not `din_last` is high.
- Error flag:
  - `err_next = 1` if `din_last` arrives at an index below NUM_CLASSES-1.
  - `err_next = 1` if index NUM_CLASSES-1 arrives without `din_last`.
  - Otherwise `err_next = 0`.
- DONE lasts exactly one cycle. During it:
  - `done = 1`.
  - `class_idx`, `max_val` and `err` are registered values for that sample.
  - A `din_valid` in DONE is accepted as index 0 of a new sample, with the same behaviour as IDLE.
  - With no `din_valid` in DONE, return to IDLE.
- A cycle with `din_valid = 0` in SCAN leaves all state unchanged. Gaps between neurons are unlimited.
- Activation per accepted neuron: `r = (din < 0) ? 0 : din >>> SHIFT`, then `act_out = min(r, 2^AW-1)`. `act_idx` is the neuron's index within the sample.
- Comparison uses raw signed `din`, not the activation, so all-negative samples still rank correctly.
- `din_last` is ignored when `din_valid = 0`.

## Timing
- Reset (asynchronous, `rst = 0`) clears:
  - `act_out = 0`, `act_valid = 0`, `act_idx = 0`
  - `class_idx = 0`, `max_val = 0`
  - `done = 0`, `err = 0`
  - `cnt = 0`, state IDLE
- Reset mid-sample discards the partial sample and no `done` is produced.
- Activation latency is 1: a neuron accepted at edge k drives `act_out`, `act_idx` and `act_valid = 1` for the cycle after edge k. `act_valid` is 0 when no neuron was accepted.
- Result latency is 1: the last neuron accepted at edge k means `done = 1` for the cycle after edge k, and the final comparison includes that neuron.
- `class_idx`, `max_val` and `err` change only on the edge that raises `done`, and hold until the next `done`.
- Back-to-back samples are supported with zero idle cycles: a new sample's index 0 may be accepted in the same cycle `done` is high.
- Throughput is one neuron per cycle.

## Test plan
- Reset release, no input: all outputs stay 0, and `act_valid` and `done` never assert.
- Ten neurons with `din_last` on the tenth, values 5, 300, -7, 300, 12, 0, 299, 1, 2, 3:
  - `done` one cycle after the tenth neuron, with `class_idx = 1` (tie with index 3 keeps the lower index), `max_val = 300` and `err = 0`.
  - Activation outputs are 0, 4, 0, 4, 0, 0, 4, 0, 0, 0 (SHIFT = 6).
- Saturation: `din = 22'h1FFFFF` gives `act_out = 255`. `din = 16320` gives `act_out = 255`. `din = 16319` gives `act_out = 254`.
- All-negative sample −50, −3, −90, …, −100 gives `class_idx = 1` and `max_val = −3`.
- Framing errors:
  - `din_last` on the 4th neuron gives `done` with `err = 1` and `class_idx` equal to the max over 4 neurons.
  - Ten neurons without `din_last` gives `done` after the tenth with `err = 1`.
- Back-to-back plus reset: two samples with no gap each give a correct `done`, and `cnt` restarts at 0. In a third sample, `rst = 0` after 5 neurons followed by release produces no `done`, and outputs read 0.
